// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V pipeline: operand forwarding, ALU and the
// EX/MEM pipeline register, plus hazard-visible wires for the hazard unit.
module execute_cycle #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteE,
  input  logic               MemtoRegE,
  input  logic               MemWriteE,
  input  logic               ALUSrcE,
  input  logic [2:0]         ALUControlE,
  input  logic [WIDTH-1:0]   RD1E,
  input  logic [WIDTH-1:0]   RD2E,
  input  logic [WIDTH-1:0]   SignImmE,
  input  logic [REGADDR-1:0] RS1E,
  input  logic [REGADDR-1:0] RS2E,
  input  logic [REGADDR-1:0] RdE,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [WIDTH-1:0]   ResultW,
  input  logic [WIDTH-1:0]   ReadDataM,
  output logic               RegWriteM,
  output logic               MemtoRegM,
  output logic               MemWriteM,
  output logic [WIDTH-1:0]   ALUOutM,
  output logic [WIDTH-1:0]   WriteDataM,
  output logic [REGADDR-1:0] WriteRegM,
  output logic [REGADDR-1:0] WriteRegE,
  output logic               MemtoRegE_h
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  logic [WIDTH-1:0]   src_a_e;
  logic [WIDTH-1:0]   write_data_e;
  logic [WIDTH-1:0]   src_b_e;
  logic [WIDTH-1:0]   alu_result_e;
  logic [4:0]         shamt_e;

  logic               reg_write_d, reg_write_q;
  logic               mem_to_reg_d, mem_to_reg_q;
  logic               mem_write_d, mem_write_q;
  logic [WIDTH-1:0]   alu_out_d, alu_out_q;
  logic [WIDTH-1:0]   write_data_d, write_data_q;
  logic [REGADDR-1:0] write_reg_d, write_reg_q;

  // Source indices and load data are carried for the hazard unit only; load-use
  // is resolved by a stall, so ReadDataM is never a forwarding source here.
  logic unused_inputs;
  assign unused_inputs = ^{RS1E, RS2E, ReadDataM};

  function automatic logic [WIDTH-1:0] forward_sel(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] reg_val,
    input logic [WIDTH-1:0] alu_out_prev,
    input logic [WIDTH-1:0] result_w
  );
    case (sel)
      2'b00:   return reg_val;
      2'b01:   return alu_out_prev;
      2'b10:   return result_w;
      default: return '0;
    endcase
  endfunction

  assign src_a_e      = forward_sel(ForwardAE, RD1E, alu_out_q, ResultW);
  assign write_data_e = forward_sel(ForwardBE, RD2E, alu_out_q, ResultW);
  assign src_b_e      = ALUSrcE ? SignImmE : write_data_e;
  assign shamt_e      = src_b_e[4:0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    alu_result_e = '0;
    case (alu_op_e'(ALUControlE))
      ALU_ADD: alu_result_e = src_a_e + src_b_e;
      ALU_SUB: alu_result_e = src_a_e - src_b_e;
      ALU_AND: alu_result_e = src_a_e & src_b_e;
      ALU_OR:  alu_result_e = src_a_e | src_b_e;
      ALU_XOR: alu_result_e = src_a_e ^ src_b_e;
      ALU_SLT: alu_result_e = {{(WIDTH-1){1'b0}}, $signed(src_a_e) < $signed(src_b_e)};
      ALU_SLL: alu_result_e = src_a_e << shamt_e;
      ALU_SRL: alu_result_e = src_a_e >> shamt_e;
      default: alu_result_e = '0;
    endcase
  end

  // Synchronous reset folds into next-state so rst wins over any inputs.
  always_comb begin
    reg_write_d  = RegWriteE;
    mem_to_reg_d = MemtoRegE;
    mem_write_d  = MemWriteE;
    alu_out_d    = alu_result_e;
    write_data_d = write_data_e;
    write_reg_d  = RdE;
    if (rst) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      alu_out_d    = '0;
      write_data_d = '0;
      write_reg_d  = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, which is what ALUOutM forwarding relies on.
  always_ff @(posedge clk) begin
    reg_write_q  <= reg_write_d;
    mem_to_reg_q <= mem_to_reg_d;
    mem_write_q  <= mem_write_d;
    alu_out_q    <= alu_out_d;
    write_data_q <= write_data_d;
    write_reg_q  <= write_reg_d;
  end

  assign RegWriteM   = reg_write_q;
  assign MemtoRegM   = mem_to_reg_q;
  assign MemWriteM   = mem_write_q;
  assign ALUOutM     = alu_out_q;
  assign WriteDataM  = write_data_q;
  assign WriteRegM   = write_reg_q;
  assign WriteRegE   = RdE;
  assign MemtoRegE_h = MemtoRegE;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed vector table, a hand-written
// same-cycle sequence, then randomized stimulus against an arithmetic model.
module tb_execute_cycle;

  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE, ResultW, ReadDataM;
  logic [4:0]  RS1E, RS2E, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteM, MemtoRegM, MemWriteM, MemtoRegE_h;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM, WriteRegE;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_alu_q;

  always #5 clk = ~clk;

  execute_cycle #(.WIDTH(32), .REGADDR(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE),
    .RS1E(RS1E), .RS2E(RS2E), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .ReadDataM(ReadDataM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .WriteRegE(WriteRegE), .MemtoRegE_h(MemtoRegE_h)
  );

  typedef struct {
    logic        rst, regw, mtr, mw, alusrc;
    logic [2:0]  ctl;
    logic [31:0] rd1, rd2, imm, resw, readm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  fa, fb;
    logic        e_regw, e_mtr, e_mw;
    logic [31:0] e_alu, e_wd;
    logic [4:0]  e_wreg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference ALU computed with wide integer arithmetic rather than bit operators.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned r  = 0;
    longint sa = a[31] ? longint'(ua) - longint'(MOD) : longint'(ua);
    longint sb = b[31] ? longint'(ub) - longint'(MOD) : longint'(ub);
    int sh = int'(ub % 32);
    case (op)
      3'd0: r = (ua + ub) % MOD;
      3'd1: r = (ua + MOD - ub) % MOD;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = (ua * (64'd1 << sh)) % MOD;
      default: r = ua / (64'd1 << sh);
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rv,
                                          input logic [31:0] resw);
    case (sel)
      2'd0: return rv;
      2'd1: return model_alu_q;
      2'd2: return resw;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; RegWriteE = v.regw; MemtoRegE = v.mtr; MemWriteE = v.mw;
    ALUSrcE = v.alusrc; ALUControlE = v.ctl;
    RD1E = v.rd1; RD2E = v.rd2; SignImmE = v.imm; ResultW = v.resw; ReadDataM = v.readm;
    RS1E = v.rs1; RS2E = v.rs2; RdE = v.rd; ForwardAE = v.fa; ForwardBE = v.fb;
  endtask

  // Drive one instruction, check the E-stage wires, clock it, check the M outputs.
  task automatic apply(input vec_t v, input bit use_table, input string tag);
    logic [31:0] wd, b, res;
    vec_t e;
    drive(v);
    #1;
    check({tag, " WriteRegE"}, 32'(WriteRegE), 32'(v.rd));
    check({tag, " MemtoRegE_h"}, 32'(MemtoRegE_h), 32'(v.mtr));
    wd  = ref_fwd(v.fb, v.rd2, v.resw);
    b   = v.alusrc ? v.imm : wd;
    res = ref_alu(v.ctl, ref_fwd(v.fa, v.rd1, v.resw), b);
    e = v;
    if (!use_table) begin
      e.e_regw = v.rst ? 1'b0 : v.regw;
      e.e_mtr  = v.rst ? 1'b0 : v.mtr;
      e.e_mw   = v.rst ? 1'b0 : v.mw;
      e.e_alu  = v.rst ? 32'd0 : res;
      e.e_wd   = v.rst ? 32'd0 : wd;
      e.e_wreg = v.rst ? 5'd0 : v.rd;
    end
    @(posedge clk);
    #1;
    model_alu_q = v.rst ? 32'd0 : res;
    check({tag, " RegWriteM"}, 32'(RegWriteM), 32'(e.e_regw));
    check({tag, " MemtoRegM"}, 32'(MemtoRegM), 32'(e.e_mtr));
    check({tag, " MemWriteM"}, 32'(MemWriteM), 32'(e.e_mw));
    check({tag, " ALUOutM"}, ALUOutM, e.e_alu);
    check({tag, " WriteDataM"}, WriteDataM, e.e_wd);
    check({tag, " WriteRegM"}, 32'(WriteRegM), 32'(e.e_wreg));
  endtask

  initial begin
    vec_t z, r;
    z = '{default: 0};
    drive(z);
    rst = 1'b1;
    model_alu_q = 32'd0;
    @(posedge clk);
    #1;

    // Reset wins over live inputs, then the first instruction is captured.
    vecs.push_back('{rst:1, regw:1, rd:5, rd1:7, default:0});
    vecs.push_back('{regw:1, rd:5, rd1:7, e_regw:1, e_alu:7, e_wreg:5, default:0});
    // add/sub/slt on -1 and 1, plus signed-overflow boundaries
    vecs.push_back('{rd1:32'hFFFF_FFFF, rd2:1, ctl:0, e_alu:0, e_wd:1, default:0});
    vecs.push_back('{rd1:32'hFFFF_FFFF, rd2:1, ctl:1, e_alu:32'hFFFF_FFFE, e_wd:1, default:0});
    vecs.push_back('{rd1:32'hFFFF_FFFF, rd2:1, ctl:5, e_alu:1, e_wd:1, default:0});
    vecs.push_back('{rd1:32'h8000_0000, rd2:1, ctl:5, e_alu:1, e_wd:1, default:0});
    vecs.push_back('{rd1:1, rd2:32'h8000_0000, ctl:5, e_alu:0, e_wd:32'h8000_0000, default:0});
    vecs.push_back('{rd1:32'h8000_0000, rd2:1, ctl:1, e_alu:32'h7FFF_FFFF, e_wd:1, default:0});
    // Immediate operand and shifts, including shamt 31 and shamt taken from bits [4:0]
    vecs.push_back('{alusrc:1, imm:4, rd1:32'h10, rd2:32'hAB, ctl:6, e_alu:32'h100, e_wd:32'hAB, default:0});
    vecs.push_back('{alusrc:1, imm:4, rd1:32'h10, rd2:32'hAB, ctl:7, e_alu:1, e_wd:32'hAB, default:0});
    vecs.push_back('{alusrc:1, imm:31, rd1:32'hFFFF_FFFF, ctl:6, e_alu:32'h8000_0000, default:0});
    vecs.push_back('{alusrc:1, imm:31, rd1:32'hFFFF_FFFF, ctl:7, e_alu:1, default:0});
    vecs.push_back('{alusrc:1, imm:32'h21, rd1:1, ctl:6, e_alu:2, default:0});
    // Logic ops
    vecs.push_back('{rd1:32'hF0F0_F0F0, rd2:32'h0FF0_0FF0, ctl:2, e_alu:32'h00F0_00F0, e_wd:32'h0FF0_0FF0, default:0});
    vecs.push_back('{rd1:32'hF0F0_F0F0, rd2:32'h0FF0_0FF0, ctl:3, e_alu:32'hFFF0_FFF0, e_wd:32'h0FF0_0FF0, default:0});
    vecs.push_back('{rd1:32'hF0F0_F0F0, rd2:32'h0FF0_0FF0, ctl:4, e_alu:32'hFF00_FF00, e_wd:32'h0FF0_0FF0, default:0});
    // Forward chain: ALUOutM then ResultW, then select 11 forcing zero
    vecs.push_back('{regw:1, rd:6, rd1:3, rd2:4, e_regw:1, e_wreg:6, e_alu:7, e_wd:4, default:0});
    vecs.push_back('{fa:1, alusrc:1, imm:1, e_alu:8, default:0});
    vecs.push_back('{fb:2, resw:32'h20, rd1:1, e_alu:32'h21, e_wd:32'h20, default:0});
    vecs.push_back('{fa:3, rd1:99, rd2:5, e_alu:5, e_wd:5, default:0});
    // Store data forwarded from ALUOutM
    vecs.push_back('{alusrc:1, rd1:32'h50, imm:5, e_alu:32'h55, default:0});
    vecs.push_back('{mw:1, alusrc:1, fb:1, rd1:32'h100, imm:8, rd2:32'hDEAD, e_mw:1, e_alu:32'h108, e_wd:32'h55, default:0});
    // Load, then a bubble
    vecs.push_back('{mtr:1, regw:1, rd:9, rd1:32'h1000, imm:32'h10, alusrc:1, e_mtr:1, e_regw:1, e_wreg:9, e_alu:32'h1010, default:0});
    vecs.push_back(z);
    // Mid-stream reset clears ALUOutM, so a following forward sees zero
    vecs.push_back('{rst:1, regw:1, rd:7, rd1:3, rd2:3, default:0});
    vecs.push_back('{regw:1, rd:7, fa:1, rd2:9, e_regw:1, e_wreg:7, e_alu:9, e_wd:9, default:0});
    vecs.push_back('{fa:1, fb:1, e_alu:32'h12, e_wd:9, default:0});

    foreach (vecs[i]) apply(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // WriteRegE follows RdE combinationally within one cycle
    r = z;
    r.rd = 5'd3;
    drive(r);
    #1 check("same-cycle WriteRegE a", 32'(WriteRegE), 32'd3);
    RdE = 5'd17;
    MemtoRegE = 1'b1;
    #1 check("same-cycle WriteRegE b", 32'(WriteRegE), 32'd17);
    check("same-cycle MemtoRegE_h", 32'(MemtoRegE_h), 32'd1);
    r.rd = 5'd17;
    r.mtr = 1'b1;
    apply(r, 1'b0, "same-cycle");

    for (int i = 0; i < 300; i++) begin
      r.rst    = ($urandom_range(0, 15) == 0);
      r.regw   = 1'($urandom);
      r.mtr    = 1'($urandom);
      r.mw     = 1'($urandom);
      r.alusrc = 1'($urandom);
      r.ctl    = 3'($urandom_range(0, 7));
      r.rd1    = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> $urandom_range(0, 31) : $urandom;
      r.rd2    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r.imm    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      r.resw   = $urandom;
      r.readm  = $urandom;
      r.rs1    = 5'($urandom);
      r.rs2    = 5'($urandom);
      r.rd     = 5'($urandom);
      r.fa     = 2'($urandom);
      r.fb     = 2'($urandom);
      apply(r, 1'b0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage pipelined RISC-V core; sits between the ID/EX register outputs and the memory stage.
- Forwards operands, performs the ALU operation and drives the EX/MEM pipeline register.
- Provides its own registered ALU result (ALUOutM) as a forwarding source, plus combinational hazard-visible signals for the hazard unit.

Parameters:
- WIDTH, 32, datapath width
- REGADDR, 5, register-index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- RegWriteE  in  1  write-back enable from ID/EX
- MemtoRegE  in  1  load result select from ID/EX
- MemWriteE  in  1  store enable from ID/EX
- ALUSrcE  in  1  1 selects SignImmE as operand B
- ALUControlE  in  3  ALU operation code
- RD1E  in  WIDTH  rs1 data from ID/EX
- RD2E  in  WIDTH  rs2 data from ID/EX
- SignImmE  in  WIDTH  extended immediate
- RS1E  in  REGADDR  rs1 index
- RS2E  in  REGADDR  rs2 index
- RdE  in  REGADDR  destination index
- ForwardAE  in  2  operand-A forward select
- ForwardBE  in  2  operand-B forward select
- ResultW  in  WIDTH  write-back value
- ReadDataM  in  WIDTH  memory-stage load data
- RegWriteM  out  1  registered RegWriteE
- MemtoRegM  out  1  registered MemtoRegE
- MemWriteM  out  1  registered MemWriteE
- ALUOutM  out  WIDTH  registered ALU result
- WriteDataM  out  WIDTH  registered forwarded operand B (pre-immediate mux)
- WriteRegM  out  REGADDR  registered RdE
- WriteRegE  out  REGADDR  combinational RdE, for the hazard unit
- MemtoRegE_h  out  1  combinational MemtoRegE, for load-use detection

Behaviour:
- Forward muxes (same encoding as the decode-stage branch forwarding):
  - 00 → RDxE
  - 01 → ALUOutM (internal register)
  - 10 → ResultW
  - 11 → 0
  - ReadDataM is not selectable here; load-use is resolved by a hazard-unit stall.
- SrcAE = forwarded A.
- WriteDataE = forwarded B.
- SrcBE = ALUSrcE ? SignImmE : WriteDataE.
- ALUControlE encoding:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed, result 0/1 zero-extended)
  - 110 sll by SrcBE[4:0]
  - 111 srl by SrcBE[4:0]
- Arithmetic wraps modulo 2^WIDTH; overflow is not flagged.
- slt uses a true signed compare, correct on overflow (e.g. 0x80000000 < 1 → 1).
- Latency: one cycle. Inputs sampled at posedge N appear on the *M outputs after posedge N.
- EX/MEM register on posedge clk:
  - rst=1: all *M outputs ← 0.
  - Otherwise: RegWriteM←RegWriteE, MemtoRegM←MemtoRegE, MemWriteM←MemWriteE, ALUOutM←ALUResultE, WriteDataM←WriteDataE, WriteRegM←RdE.
- A bubble inserted by the decode-stage FlushE arrives as all-zero controls and propagates as a harmless add of x0 → x0 (RegWriteM=0, MemWriteM=0).
- Forwarding from ALUOutM uses the register value before the current edge (previous instruction). Back-to-back dependent ALU ops therefore resolve with zero stall.
- rst asserted mid-stream: the next edge clears the register regardless of inputs. The first instruction after rst deasserts is captured normally.
- WriteRegE and MemtoRegE_h are pure wires, valid in the same cycle as the E inputs.
- No stall input: the hazard unit freezes upstream stages and inserts a bubble via FlushE.

Test Plan:
- Reset: drive rst=1 with RegWriteE=1, RdE=5, RD1E=7 for one edge → all *M outputs 0. Release rst → next edge gives RegWriteM=1, WriteRegM=5.
- Add/sub/slt: RD1E=0xFFFFFFFF, RD2E=1, ALUSrcE=0:
  - ALUControlE=000 → ALUOutM=0x00000000
  - 001 → 0xFFFFFFFE
  - 101 → 0x00000001
- Immediate and shift: ALUSrcE=1, SignImmE=4, RD1E=0x10:
  - 110 → ALUOutM=0x100
  - 111 → 0x1
  - RD2E=0xAB passes to WriteDataM=0xAB
- Forward chain: cycle 1 add 3+4 → ALUOutM=7. Cycle 2 ForwardAE=01, RD1E=0, SignImmE=1, ALUSrcE=1 → ALUOutM=8. Cycle 3 ForwardBE=10, ResultW=0x20, ALUSrcE=0, ForwardAE=00, RD1E=1 → ALUOutM=0x21.
- Store data forwarding: MemWriteE=1, ALUSrcE=1, ForwardBE=01 with ALUOutM=0x55 → WriteDataM=0x55, MemWriteM=1, ALUOutM=RD1E+imm.
- Bubble: all-zero control/data inputs following a valid op → RegWriteM=0, MemWriteM=0, ALUOutM=0 next cycle. WriteRegE tracks RdE combinationally within the same cycle.
